ps2_hex_keypad: RTL and testbench

// - Receives PS/2 keyboard frames and turns make codes for keys 0-9 and A-F into a 4-bit hex nibble.
// - Its hex output drives the nibble input of the 7-segment hex decoder.
// - It is the keyboard end of the keyboard -> display path.
// - Break sequences (F0 xx) and extended sequences (E0 xx) are consumed and never produce a nibble.

---
 rtl/ps2_hex_keypad_if.sv | 19 +
 rtl/ps2_hex_keypad.sv | 173 +++++++++++++++++
 tb/tb_ps2_hex_keypad.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_hex_keypad_if.sv
// PS/2 keypad bundle: raw pad lines in, decoded nibble and strobes out.
// The master side drives the PS/2 lines; the slave side is the decoder.
interface ps2_hex_keypad_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [3:0] hex;
   logic       hex_valid;
   logic       rx_err;

   modport master (
      output ps2_clk, ps2_data,
      input  hex, hex_valid, rx_err
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output hex, hex_valid, rx_err
   );
endinterface

// File: rtl/ps2_hex_keypad.sv
// PS/2 device-to-host receiver that turns make codes for 0-9/A-F into a hex nibble.
// Break (F0 xx) and extended (E0 xx) sequences are swallowed without producing output.
module ps2_hex_keypad #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000
) (
   input logic             clk,
   input logic             rst,
   ps2_hex_keypad_if.slave kb
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);
   localparam logic [3:0]    FL_MAX = 4'(FILTER_LEN - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // Input synchronisers and clock filter
   logic       clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic       dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   logic       filt_q, filt_d;
   logic [3:0] fcnt_q, fcnt_d;
   logic       fall;

   // Frame state
   state_t          state_q;
   logic [2:0]      bcnt_q;
   logic [7:0]      sh_q;
   logic            par_q;
   logic [TW-1:0]   to_q;
   logic            break_f_q;
   logic            ext_f_q;
   logic [3:0]      hex_q;
   logic            hex_valid_q;
   logic            rx_err_q;

   logic [4:0]      map_w;
   logic            frame_ok;

   function automatic logic [4:0] hex_map(input logic [7:0] code);
      logic [4:0] r;
      r = 5'h00;
      unique case (code)
         8'h45: r = {1'b1, 4'h0};
         8'h16: r = {1'b1, 4'h1};
         8'h1E: r = {1'b1, 4'h2};
         8'h26: r = {1'b1, 4'h3};
         8'h25: r = {1'b1, 4'h4};
         8'h2E: r = {1'b1, 4'h5};
         8'h36: r = {1'b1, 4'h6};
         8'h3D: r = {1'b1, 4'h7};
         8'h3E: r = {1'b1, 4'h8};
         8'h46: r = {1'b1, 4'h9};
         8'h1C: r = {1'b1, 4'hA};
         8'h32: r = {1'b1, 4'hB};
         8'h21: r = {1'b1, 4'hC};
         8'h23: r = {1'b1, 4'hD};
         8'h24: r = {1'b1, 4'hE};
         8'h2B: r = {1'b1, 4'hF};
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   always_comb begin
      clk_s1_d = kb.ps2_clk;
      clk_s2_d = clk_s1_q;
      dat_s1_d = kb.ps2_data;
      dat_s2_d = dat_s1_q;
      filt_d   = filt_q;
      fcnt_d   = '0;
      // Count consecutive samples that disagree with the filtered level;
      // the FILTER_LEN-th one flips it.
      if (clk_s2_q != filt_q) begin
         if (fcnt_q == FL_MAX) filt_d = clk_s2_q;
         else                  fcnt_d = fcnt_q + 4'd1;
      end
   end

   assign fall     = filt_q & ~filt_d;
   assign map_w    = hex_map(sh_q);
   // Stop bit high and odd parity over data plus parity bit
   assign frame_ok = dat_s2_q & (^{sh_q, par_q});

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
         filt_q   <= 1'b1;
         fcnt_q   <= '0;
      end else begin
         clk_s1_q <= clk_s1_d;
         clk_s2_q <= clk_s2_d;
         dat_s1_q <= dat_s1_d;
         dat_s2_q <= dat_s2_d;
         filt_q   <= filt_d;
         fcnt_q   <= fcnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bcnt_q      <= '0;
         sh_q        <= '0;
         par_q       <= 1'b0;
         to_q        <= '0;
         break_f_q   <= 1'b0;
         ext_f_q     <= 1'b0;
         hex_q       <= '0;
         hex_valid_q <= 1'b0;
         rx_err_q    <= 1'b0;
      end else begin
         hex_valid_q <= 1'b0;
         rx_err_q    <= 1'b0;
         if (fall) begin
            to_q <= '0;
            unique case (state_q)
               IDLE: begin
                  if (!dat_s2_q) begin
                     state_q <= DATA;
                     bcnt_q  <= '0;
                  end
               end
               DATA: begin
                  sh_q   <= {dat_s2_q, sh_q[7:1]};
                  bcnt_q <= bcnt_q + 3'd1;
                  if (bcnt_q == 3'd7) state_q <= PARITY;
               end
               PARITY: begin
                  par_q   <= dat_s2_q;
                  state_q <= STOP;
               end
               STOP: begin
                  state_q <= IDLE;
                  if (frame_ok) begin
                     if (sh_q == 8'hF0) begin
                        break_f_q <= 1'b1;
                     end else if (sh_q == 8'hE0) begin
                        ext_f_q <= 1'b1;
                     end else if (break_f_q || ext_f_q) begin
                        // Second byte of a break/extended pair: consume it
                        break_f_q <= 1'b0;
                        ext_f_q   <= 1'b0;
                     end else if (map_w[4]) begin
                        hex_q       <= map_w[3:0];
                        hex_valid_q <= 1'b1;
                     end
                  end else begin
                     rx_err_q <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end else if (state_q != IDLE) begin
            if (to_q == TO_MAX) begin
               rx_err_q <= 1'b1;
               state_q  <= IDLE;
               to_q     <= '0;
            end else begin
               to_q <= to_q + TW'(1);
            end
         end
      end
   end

   assign kb.hex       = hex_q;
   assign kb.hex_valid = hex_valid_q;
   assign kb.rx_err    = rx_err_q;

endmodule

// File: tb/tb_ps2_hex_keypad.sv
// Randomised PS/2 frame bench for ps2_hex_keypad with a key-sequence reference model.
// Strobes are logged per cycle and compared against the model after every frame.
module tb_ps2_hex_keypad;
   localparam int FL = 4;
   localparam int TO = 400;

   logic clk = 1'b0;
   logic rst = 1'b1;
   ps2_hex_keypad_if kb ();

   ps2_hex_keypad #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .kb  (kb.slave)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;
   int hp;

   int         vq[$];
   logic [3:0] hq[$];
   int         eq[$];
   int         both_cnt = 0;

   always @(negedge clk) begin
      if (kb.hex_valid === 1'b1) begin
         vq.push_back(cyc);
         hq.push_back(kb.hex);
      end
      if (kb.rx_err === 1'b1) eq.push_back(cyc);
      if (kb.hex_valid === 1'b1 && kb.rx_err === 1'b1) both_cnt++;
   end

   // Reference model: key sequence state
   logic [7:0] keys [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                             8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
   logic [3:0] m_hex = 4'h0;
   bit         m_brk = 0;
   bit         m_ext = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_byte(input logic [7:0] b, output bit v, output logic [3:0] nib);
      v = 0;
      nib = m_hex;
      if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else if (m_brk || m_ext) begin
         m_brk = 0;
         m_ext = 0;
      end else begin
         for (int i = 0; i < 16; i++)
            if (keys[i] == b) begin
               v = 1;
               nib = 4'(i);
               m_hex = 4'(i);
            end
      end
   endtask

   task automatic clear_log();
      vq.delete();
      hq.delete();
      eq.delete();
   endtask

   task automatic put_bit(input logic b, input bit glitch, output int fc);
      @(negedge clk);
      kb.ps2_data = b;
      if (glitch) begin
         repeat (FL + 6) @(negedge clk);
         kb.ps2_clk = 1'b0;
         repeat ($urandom_range(FL - 1, 1)) @(negedge clk);
         kb.ps2_clk = 1'b1;
      end
      repeat (hp) @(negedge clk);
      kb.ps2_clk = 1'b0;
      fc = cyc;
      repeat (hp) @(negedge clk);
      kb.ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int gl_bit);
      logic [10:0] bits;
      int          fc;
      int          sc;
      bit          ev;
      logic [3:0]  en;
      hp = $urandom_range(20, 10);
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      clear_log();
      sc = 0;
      for (int i = 0; i < 11; i++) begin
         put_bit(bits[i], i == gl_bit, fc);
         sc = fc;
      end
      repeat (FL + 8) @(negedge clk);
      ev = 0;
      en = m_hex;
      if (!bad_par && !bad_stop) model_byte(b, ev, en);
      chk("vld_count", 32'(vq.size()), 32'(ev));
      if (ev && vq.size() == 1) begin
         chk("vld_latency", 32'(vq[0]), 32'(sc + FL + 2));
         chk("hex_value", 32'(hq[0]), 32'(en));
      end
      chk("err_count", 32'(eq.size()), 32'(bad_par || bad_stop));
      if ((bad_par || bad_stop) && eq.size() == 1)
         chk("err_latency", 32'(eq[0]), 32'(sc + FL + 2));
      chk("hex_hold", 32'(kb.hex), 32'(m_hex));
      chk("no_overlap", 32'(both_cnt), 32'd0);
   endtask

   task automatic send_timeout(input int nbits);
      int fc;
      int lf;
      hp = $urandom_range(20, 10);
      clear_log();
      put_bit(1'b0, 0, fc);
      lf = fc;
      for (int i = 0; i < nbits; i++) begin
         put_bit(1'($urandom_range(1, 0)), 0, fc);
         lf = fc;
      end
      repeat (TO + FL + 12) @(negedge clk);
      chk("to_err_count", 32'(eq.size()), 32'd1);
      if (eq.size() == 1)
         chk("to_err_window", 32'(eq[0] >= lf + TO && eq[0] <= lf + TO + FL + 4), 32'd1);
      chk("to_no_vld", 32'(vq.size()), 32'd0);
      chk("to_hex_hold", 32'(kb.hex), 32'(m_hex));
   endtask

   initial begin
      int fc;
      int r;
      logic [7:0] b;
      kb.ps2_clk  = 1'b1;
      kb.ps2_data = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_hex", 32'(kb.hex), 32'd0);
      chk("rst_hex_valid", 32'(kb.hex_valid), 32'd0);
      chk("rst_rx_err", 32'(kb.rx_err), 32'd0);
      rst = 1'b0;
      clear_log();
      repeat (200) @(negedge clk);
      chk("idle_no_vld", 32'(vq.size()), 32'd0);
      chk("idle_no_err", 32'(eq.size()), 32'd0);

      send_frame(8'h1C, 0, 0, -1);
      send_frame(8'h45, 0, 0, -1);
      send_frame(8'h2B, 0, 0, -1);
      send_frame(8'hF0, 0, 0, -1);
      send_frame(8'h2B, 0, 0, -1);
      send_frame(8'hE0, 0, 0, -1);
      send_frame(8'h16, 0, 0, -1);
      chk("hex_after_ext", 32'(kb.hex), 32'hF);
      send_frame(8'h16, 1, 0, -1);
      send_frame(8'h16, 0, 1, -1);
      send_timeout(4);
      send_frame(8'h26, 0, 0, -1);
      send_frame(8'h3D, 0, 0, 5);

      // Reset during bit 5 of a frame, with the PS/2 clock high
      hp = 12;
      clear_log();
      put_bit(1'b0, 0, fc);
      for (int i = 0; i < 5; i++) put_bit(1'b1, 0, fc);
      @(negedge clk);
      kb.ps2_data = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      kb.ps2_data = 1'b1;
      m_hex = 4'h0;
      m_brk = 0;
      m_ext = 0;
      repeat (60) @(negedge clk);
      chk("midrst_no_vld", 32'(vq.size()), 32'd0);
      chk("midrst_no_err", 32'(eq.size()), 32'd0);
      chk("midrst_hex", 32'(kb.hex), 32'd0);
      send_frame(8'h2E, 0, 0, -1);

      for (int n = 0; n < 50; n++) begin
         r = $urandom_range(99, 0);
         if (r < 50) b = keys[$urandom_range(15, 0)];
         else if (r < 65) b = 8'hF0;
         else if (r < 75) b = 8'hE0;
         else b = 8'($urandom_range(255, 0));
         r = $urandom_range(99, 0);
         if (r < 4) send_timeout($urandom_range(8, 1));
         else send_frame(b, r >= 4 && r < 12, r >= 12 && r < 17,
                         ($urandom_range(4, 0) == 0) ? $urandom_range(10, 0) : -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
